ex_muldiv_unit: RTL and testbench

- Multi-cycle RV32M execute unit. Sits downstream of the decode stage, alongside the single-cycle ALU in EX.
- Accepts decoded operands for MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU and returns a 32-bit result plus the destination register.
- Asserts busy so the hazard logic stalls IF/ID/EX while an operation is in flight.

---
 rtl/ex_muldiv_unit.sv | 206 ++++++++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// RV32M execute unit: single-cycle-issue 33x33 multiplier and
// radix-2 restoring divider, one operation in flight at a time.
module ex_muldiv_unit #(
    parameter int XLEN      = 32,
    parameter int DIV_ITERS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            flush_i,
    output logic            busy_o,
    output logic            out_valid_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      out_rd_addr_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [1:0]  r_f3;
    logic [4:0]  r_rd;
    logic [32:0] r_a;
    logic [32:0] r_b;
    logic [31:0] r_quot;
    logic [31:0] r_rem;
    logic [31:0] r_dvs;
    logic [4:0]  r_cnt;
    logic        r_neg_q;
    logic        r_neg_r;
    logic [31:0] r_result;
    logic [4:0]  r_out_rd;

    logic        w_accept;
    logic        w_sgn;
    logic        w_div0;
    logic        w_ovf;
    logic        w_special;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_spec_res;
    logic        w_a_sx;
    logic        w_b_sx;
    logic [63:0] w_ax;
    logic [63:0] w_bx;
    logic [63:0] w_prod;
    logic [31:0] w_mul_res;
    logic [32:0] w_shift;
    logic        w_ge;
    logic [31:0] w_sub;
    logic [31:0] w_rem_nx;
    logic [31:0] w_q_fin;
    logic [31:0] w_div_res;
    logic        w_div_last;

    assign in_ready_o  = (r_state == S_IDLE) && !rst && !flush_i;
    assign w_accept    = in_valid_i && in_ready_o;
    assign busy_o      = (r_state != S_IDLE);
    assign out_valid_o = (r_state == S_DONE) && !flush_i && !rst;
    assign result_o      = r_result;
    assign out_rd_addr_o = r_out_rd;

    // Divide operand preparation and the two architecturally defined corner cases
    assign w_sgn     = ~funct3_i[0];
    assign w_div0    = (rs2_data_i == 32'h0);
    assign w_ovf     = w_sgn && (rs1_data_i == 32'h8000_0000)
                       && (rs2_data_i == 32'hFFFF_FFFF);
    assign w_special = w_div0 || w_ovf;
    assign w_a_neg   = w_sgn && rs1_data_i[31];
    assign w_b_neg   = w_sgn && rs2_data_i[31];
    assign w_a_mag   = w_a_neg ? (32'h0 - rs1_data_i) : rs1_data_i;
    assign w_b_mag   = w_b_neg ? (32'h0 - rs2_data_i) : rs2_data_i;

    // Divide-by-zero beats overflow; REM variants select the remainder form
    always_comb begin
        w_spec_res = 32'h0;
        if (w_div0) begin
            w_spec_res = funct3_i[1] ? rs1_data_i : 32'hFFFF_FFFF;
        end else begin
            w_spec_res = funct3_i[1] ? 32'h0 : 32'h8000_0000;
        end
    end

    // Multiplier: operands carried as 33-bit values so one signed multiply covers all four ops
    assign w_a_sx    = (funct3_i == 3'b001) || (funct3_i == 3'b010);
    assign w_b_sx    = (funct3_i == 3'b001);
    assign w_ax      = {{31{r_a[32]}}, r_a};
    assign w_bx      = {{31{r_b[32]}}, r_b};
    assign w_prod    = w_ax * w_bx;
    assign w_mul_res = (r_f3 == 2'b00) ? w_prod[31:0] : w_prod[63:32];

    // One restoring step: shift in next dividend bit, subtract if it fits
    assign w_shift    = {r_rem, r_quot[31]};
    assign w_ge       = (w_shift >= {1'b0, r_dvs});
    assign w_sub      = w_shift[31:0] - r_dvs;
    assign w_rem_nx   = w_ge ? w_sub : w_shift[31:0];
    assign w_q_fin    = {r_quot[30:0], w_ge};
    assign w_div_last = (r_cnt == 5'(DIV_ITERS - 1));

    // Sign fix-up of the final quotient/remainder
    always_comb begin
        w_div_res = 32'h0;
        if (r_f3[1]) begin
            w_div_res = r_neg_r ? (32'h0 - w_rem_nx) : w_rem_nx;
        end else begin
            w_div_res = r_neg_q ? (32'h0 - w_q_fin) : w_q_fin;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; flush returns to IDLE from anywhere
    always_comb begin
        w_next = r_state;
        if (flush_i) begin
            w_next = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (!funct3_i[2]) begin
                            w_next = S_MUL;
                        end else if (w_special) begin
                            w_next = S_DONE;
                        end else begin
                            w_next = S_DIV;
                        end
                    end
                end
                S_MUL:  w_next = S_DONE;
                S_DIV:  w_next = w_div_last ? S_DONE : S_DIV;
                S_DONE: w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Datapath: latch on accept, iterate, capture result on entry to DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_f3     <= 2'b0;
            r_rd     <= 5'b0;
            r_a      <= 33'b0;
            r_b      <= 33'b0;
            r_quot   <= 32'b0;
            r_rem    <= 32'b0;
            r_dvs    <= 32'b0;
            r_cnt    <= 5'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= 32'b0;
            r_out_rd <= 5'b0;
        end else begin
            if (w_accept) begin
                r_f3    <= funct3_i[1:0];
                r_rd    <= rd_addr_i;
                r_a     <= {w_a_sx & rs1_data_i[31], rs1_data_i};
                r_b     <= {w_b_sx & rs2_data_i[31], rs2_data_i};
                r_quot  <= w_a_mag;
                r_dvs   <= w_b_mag;
                r_rem   <= 32'b0;
                r_cnt   <= 5'b0;
                r_neg_q <= w_a_neg ^ w_b_neg;
                r_neg_r <= w_a_neg;
                if (funct3_i[2] && w_special) begin
                    r_result <= w_spec_res;
                    r_out_rd <= rd_addr_i;
                end
            end
            if (r_state == S_MUL && !flush_i) begin
                r_result <= w_mul_res;
                r_out_rd <= r_rd;
            end
            if (r_state == S_DIV) begin
                r_quot <= w_q_fin;
                r_rem  <= w_rem_nx;
                r_cnt  <= r_cnt + 5'd1;
                if (w_div_last && !flush_i) begin
                    r_result <= w_div_res;
                    r_out_rd <= r_rd;
                end
            end
        end
    end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed + small random bench for ex_muldiv_unit with an
// expected-result queue checked whenever the unit strobes out_valid_o.
module tb_ex_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [2:0]  funct3_i;
    logic [31:0] rs1_data_i;
    logic [31:0] rs2_data_i;
    logic [4:0]  rd_addr_i;
    logic        flush_i;
    logic        busy_o;
    logic        out_valid_o;
    logic [31:0] result_o;
    logic [4:0]  out_rd_addr_o;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_mis = 0;
    int   cyc   = 0;

    ex_muldiv_unit dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .funct3_i      (funct3_i),
        .rs1_data_i    (rs1_data_i),
        .rs2_data_i    (rs2_data_i),
        .rd_addr_i     (rd_addr_i),
        .flush_i       (flush_i),
        .busy_o        (busy_o),
        .out_valid_o   (out_valid_o),
        .result_o      (result_o),
        .out_rd_addr_o (out_rd_addr_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_op(logic [2:0] f, logic [31:0] a, logic [31:0] b);
        longint sa;
        longint sb;
        longint ua;
        longint ub;
        logic [63:0] p;
        int ia;
        int ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        ia = a;
        ib = b;
        p  = 64'h0;
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return ia / ib;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int lat_of(logic [2:0] f, logic [31:0] a, logic [31:0] b);
        if (!f[2]) return 2;
        if (b == 0) return 1;
        if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Call #1 after a rising edge; returns #1 after the accepting edge
    task automatic issue(input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd,
                         input logic [31:0] exp, input int lat,
                         input bit push, input bit hold, output int c);
        int k;
        exp_t e;
        funct3_i   = f;
        rs1_data_i = a;
        rs2_data_i = b;
        rd_addr_i  = rd;
        in_valid_i = 1'b1;
        k = 0;
        @(negedge clk);
        while (!in_ready_o && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready_o) begin
            chk("accept_timeout", {31'h0, in_ready_o}, 32'h1);
        end
        c = cyc;
        if (push) begin
            e.res = exp;
            e.rd  = rd;
            e.cyc = c + lat;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        if (!hold) in_valid_i = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (q.size() != 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("drain", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every strobe must match the oldest expected entry
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (busy_o) chk("ready_while_busy", {31'h0, in_ready_o}, 32'h0);
            if (out_valid_o) begin
                if (q.size() == 0) begin
                    chk("unexpected_strobe", {31'h0, out_valid_o}, 32'h0);
                end else begin
                    e = q.pop_front();
                    chk("result", result_o, e.res);
                    chk("rd", {27'h0, out_rd_addr_o}, {27'h0, e.rd});
                    chk("latency_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        #500000;
        $error("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c;
        int c2;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;

        rst        = 1'b1;
        in_valid_i = 1'b0;
        funct3_i   = 3'd0;
        rs1_data_i = 32'h0;
        rs2_data_i = 32'h0;
        rd_addr_i  = 5'd0;
        flush_i    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {31'h0, in_ready_o}, 32'h0);
        chk("rst_busy", {31'h0, busy_o}, 32'h0);
        chk("rst_valid", {31'h0, out_valid_o}, 32'h0);
        chk("rst_result", result_o, 32'h0);
        chk("rst_rd", {27'h0, out_rd_addr_o}, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Multiplies
        issue(3'd0, 32'h7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 2, 1, 0, c);
        drain();
        issue(3'd3, 32'h7, 32'hFFFF_FFFD, 5'd6, 32'h0000_0006, 2, 1, 0, c);
        drain();
        issue(3'd1, 32'h7, 32'hFFFF_FFFD, 5'd7, 32'hFFFF_FFFF, 2, 1, 0, c);
        drain();
        issue(3'd2, 32'h7, 32'hFFFF_FFFD, 5'd8, 32'h0000_0006, 2, 1, 0, c);
        drain();

        // Signed divide with busy window check
        issue(3'd4, 32'hFFFF_FF9C, 32'h7, 5'd9, 32'hFFFF_FFF2, 33, 1, 0, c);
        chk("div_busy_c1", {31'h0, busy_o}, 32'h1);
        repeat (32) @(posedge clk);
        #1;
        chk("div_busy_c33", {31'h0, busy_o}, 32'h1);
        @(posedge clk);
        #1;
        chk("div_idle_c34", {31'h0, busy_o}, 32'h0);
        drain();
        issue(3'd6, 32'hFFFF_FF9C, 32'h7, 5'd10, 32'hFFFF_FFFE, 33, 1, 0, c);
        drain();
        issue(3'd5, 32'd100, 32'd7, 5'd11, 32'd14, 33, 1, 0, c);
        drain();

        // Divide by zero and signed overflow
        issue(3'd5, 32'h1234, 32'h0, 5'd12, 32'hFFFF_FFFF, 1, 1, 0, c);
        drain();
        issue(3'd6, 32'h1234, 32'h0, 5'd13, 32'h0000_1234, 1, 1, 0, c);
        drain();
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, 1, 1, 0, c);
        drain();
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 32'h0, 1, 1, 0, c);
        drain();

        // Flush mid-divide, then a multiply right after
        issue(3'd4, 32'd1000, 32'd3, 5'd15, 32'h0, 0, 0, 0, c);
        repeat (9) @(posedge clk);
        #1;
        flush_i = 1'b1;
        @(negedge clk);
        chk("flush_ready", {31'h0, in_ready_o}, 32'h0);
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        chk("flush_idle", {31'h0, busy_o}, 32'h0);
        issue(3'd0, 32'd3, 32'd4, 5'd16, 32'd12, 2, 1, 0, c2);
        chk("flush_accept_cycle", c2, c + 11);
        drain();
        repeat (40) @(posedge clk);
        #1;

        // Back-to-back with in_valid held high
        issue(3'd0, 32'd2, 32'd3, 5'd17, 32'd6, 2, 1, 1, c);
        issue(3'd5, 32'd9, 32'd2, 5'd18, 32'd4, 33, 1, 0, c2);
        chk("b2b_accept_cycle", c2, c + 3);
        drain();

        // A few random ops against the reference model
        for (int i = 0; i < 8; i++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            if (i % 3 == 1) a = -a;
            issue(f, a, b, 5'(i + 20), ref_op(f, a, b), lat_of(f, a, b), 1, 0, c);
            drain();
        end

        // Reset in the middle of a divide
        issue(3'd4, 32'd1000, 32'd7, 5'd19, 32'h0, 0, 0, 0, c);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_ready", {31'h0, in_ready_o}, 32'h0);
        chk("midrst_valid", {31'h0, out_valid_o}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_busy", {31'h0, busy_o}, 32'h0);
        chk("midrst_result", result_o, 32'h0);
        chk("midrst_rd", {27'h0, out_rd_addr_o}, 32'h0);
        repeat (40) @(posedge clk);
        #1;
        chk("queue_empty_end", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
